uart_tx_serializer: RTL and testbench
=====================================

# uart_tx_serializer

Transmit-side stage of the CoreUARTapb UART, directly downstream of the 256x8 TX FIFO. Whenever the FIFO is non-empty, it pops one byte using the FIFO's active-low read strobe and waits out the FIFO's registered read latency. It then shifts the byte onto the serial line as a frame: start bit, 7 or 8 data bits LSB-first, optional parity, one stop bit. Each bit is paced by the x16 oversampling baud enable.

## Interface
- `RD_LATENCY`, default 2: CLK cycles from the `FIFO_RDB` low cycle to valid `FIFO_DO`. This covers the FIFO block read plus the output register. Legal range 1..3.
- `CLK` in 1: system clock; the only clock. It is the same clock as the FIFO RCLOCK.
- `RESET_N` in 1: asynchronous, active-low reset.
- `BAUD_TICK` in 1: one-CLK enable pulse at 16x the baud rate.
- `BIT8` in 1: 1 = 8 data bits, 0 = 7 data bits (`FIFO_DO[7]` ignored).
- `PARITY_EN` in 1: 1 = insert parity bit after the data bits.
- `ODD_N_EVEN` in 1: 1 = odd parity, 0 = even parity.
- `FIFO_EMPTY` in 1: FIFO empty flag.
- `FIFO_DO` in 8: FIFO read data.
- `FIFO_RDB` out 1: active-low read strobe to FIFO RE; low for exactly one CLK per pop.
- `TX` out 1: serial output; idle/stop = 1.
- `TX_BUSY` out 1: 1 from the pop until the end of the stop bit.

## Operation
- States: IDLE, FETCH, WAIT, START, DATA, PARITY, STOP.
- IDLE: `TX`=1, `TX_BUSY`=0. If `FIFO_EMPTY`=0, go to FETCH.
- FETCH (1 cycle): `FIFO_RDB`=0, `TX_BUSY`=1. Go to WAIT.
- WAIT: count `RD_LATENCY` cycles after FETCH. In the last cycle, do all of the following, then go to START:
  - capture `FIFO_DO` into the shift register;
  - latch `BIT8`, `PARITY_EN` and `ODD_N_EVEN` as the frame configuration;
  - compute parity as XOR of the 7 or 8 data bits, inverted when odd.
- Bit timing: each of START/DATA/PARITY/STOP lasts exactly 16 `BAUD_TICK` pulses.
  - 4-bit tick counter, cleared on state entry.
  - The state advances in the cycle where the 16th tick is seen.
- START: `TX`=0.
- DATA: `TX` = shift register bit 0; shift right at each bit end.
  - 3-bit bit counter.
  - Leave after 8 bits, or 7 bits when latched `BIT8`=0.
  - Go to PARITY if latched `PARITY_EN`=1, else to STOP.
- PARITY: `TX` = computed parity bit.
- STOP: `TX`=1. At the bit end:
  - if `FIFO_EMPTY`=0, go straight to FETCH (back-to-back frames; no extra idle bit);
  - else go to IDLE.
- `FIFO_RDB` is never low while `FIFO_EMPTY`=1.
- `FIFO_EMPTY` is sampled only in IDLE and at the STOP bit end.
- Config input changes mid-frame do not affect the frame in progress.
- `BAUD_TICK` is ignored in IDLE, FETCH and WAIT.

## Timing
- Reset values: `TX`=1, `FIFO_RDB`=1, `TX_BUSY`=0, state IDLE, counters 0.
  - Reset is asynchronous; asserting it mid-frame forces these values immediately.
  - The frame is abandoned; the popped byte is lost.
- Edge 0 is the edge that sees `FIFO_EMPTY`=0 in IDLE.
  - `FIFO_RDB` is low in cycle 1.
  - Data is captured at the end of cycle 1+`RD_LATENCY`.
  - `TX` falls in cycle 2+`RD_LATENCY`.
- Frame length in ticks: 16 × (1 + N + P + 1), where N = 7/8 data bits and P = 0/1 parity bit. Example: 8N1 = 160 ticks.
- `TX` is registered; there is no combinational path from any input to any output.

## Structure
- Shared package `uart_tx_pkg` holds:
  - the state enum;
  - `TICKS_PER_BIT` = 16;
  - the `RD_LATENCY` bound constants.
- Sub-module `uart_tx_bit_timer`: tick counter plus bit counter, with a "bit_done" pulse output.
- The FSM and shift register stay in the top module.

## Test plan
- Load 0x55 in the FIFO, 8N1, `BAUD_TICK` every 4 CLK.
  - `FIFO_RDB` low for exactly 1 cycle.
  - `TX` shows 0, 1,0,1,0,1,0,1,0, 1, with each bit 64 CLK wide.
  - `TX_BUSY` is 0 afterwards.
- 0xA3 with `BIT8`=0, `PARITY_EN`=1, `ODD_N_EVEN`=0.
  - Data bits 1,1,0,0,0,1,0; parity bit 1; stop bit 1.
  - Repeat with `ODD_N_EVEN`=1: parity bit is 0.
- Three bytes queued in the FIFO.
  - Three pops; frames are contiguous, each stop bit followed directly by the next start bit.
  - Exactly 3 `FIFO_RDB` pulses.
- FIFO kept empty for 1000 cycles while `BAUD_TICK` runs.
  - `FIFO_RDB` stays 1, `TX` stays 1, `TX_BUSY` stays 0.
- Assert `RESET_N` during DATA bit 3.
  - `TX`=1 and `TX_BUSY`=0 without waiting for a CLK edge.
  - After release with the FIFO non-empty, a clean new frame starts.
- Sweep `RD_LATENCY` = 1, 2, 3 with 0xFF in the FIFO and 8N1.
  - The captured byte is correct.
  - The `TX` fall occurs in cycle 2+`RD_LATENCY`.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit serializer.
// The state enum, bit timing constants and the FIFO read-latency bounds live here.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int TICKS_PER_BIT  = 16;
  localparam int TICK_W         = $clog2(TICKS_PER_BIT);
  localparam int BIT_CNT_W      = 3;
  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 3;
  localparam int WAIT_CNT_W     = $clog2(RD_LATENCY_MAX + 1);

  // Even parity makes the total count of ones even; odd parity inverts that bit.
  function automatic logic frame_parity(input logic [7:0] data,
                                        input logic       bit8,
                                        input logic       odd);
    logic [7:0] masked;
    masked = bit8 ? data : {1'b0, data[6:0]};
    return (^masked) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit timing for the serializer: counts BAUD_TICK pulses within a bit and
// counts data bits, flagging the tick that completes each bit.
module uart_tx_bit_timer
  import uart_tx_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 tick_i,
  input  logic                 count_bits_i,
  output logic                 bit_done_o,
  output logic [BIT_CNT_W-1:0] bit_cnt_o
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);

  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;

  assign bit_done_o = tick_i && !clr_i && (tick_q == TICK_LAST);
  assign bit_cnt_o  = bit_q;

  always_comb begin
    tick_d = tick_q;
    bit_d  = bit_q;
    if (clr_i) begin
      tick_d = '0;
      bit_d  = '0;
    end else begin
      if (tick_i) begin
        tick_d = bit_done_o ? '0 : tick_q + 1'b1;
      end
      // Bit counter only runs through the data bits; other states hold it at 0.
      if (!count_bits_i) begin
        bit_d = '0;
      end else if (bit_done_o) begin
        bit_d = bit_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_q <= '0;
      bit_q  <= '0;
    end else begin
      tick_q <= tick_d;
      bit_q  <= bit_d;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from the TX FIFO and shifts them out as
// start / 7-8 data bits LSB-first / optional parity / stop, paced by a x16 tick.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int RD_LATENCY = 2
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       BAUD_TICK,
  input  logic       BIT8,
  input  logic       PARITY_EN,
  input  logic       ODD_N_EVEN,
  input  logic       FIFO_EMPTY,
  input  logic [7:0] FIFO_DO,
  output logic       FIFO_RDB,
  output logic       TX,
  output logic       TX_BUSY
);

  localparam int RD_LAT = (RD_LATENCY < RD_LATENCY_MIN) ? RD_LATENCY_MIN :
                          (RD_LATENCY > RD_LATENCY_MAX) ? RD_LATENCY_MAX : RD_LATENCY;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(RD_LAT - 1);

  tx_state_e              state_q, state_d;
  logic [WAIT_CNT_W-1:0]  wait_q, wait_d;
  logic                   rdb_q, rdb_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   bit8_q, bit8_d;
  logic                   pe_q, pe_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;

  logic                   timer_clr;
  logic                   bit_done;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [BIT_CNT_W-1:0]   last_bit;

  assign timer_clr = (state_q == ST_IDLE) || (state_q == ST_FETCH) || (state_q == ST_WAIT);
  assign last_bit  = bit8_q ? BIT_CNT_W'(7) : BIT_CNT_W'(6);

  uart_tx_bit_timer u_bit_timer (
    .clk_i        (CLK),
    .rst_ni       (RESET_N),
    .clr_i        (timer_clr),
    .tick_i       (BAUD_TICK),
    .count_bits_i (state_q == ST_DATA),
    .bit_done_o   (bit_done),
    .bit_cnt_o    (bit_cnt)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    bit8_d  = bit8_q;
    pe_d    = pe_q;
    shift_d = shift_q;
    par_d   = par_q;

    case (state_q)
      ST_IDLE: begin
        if (!FIFO_EMPTY) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        wait_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          shift_d = FIFO_DO;
          bit8_d  = BIT8;
          pe_d    = PARITY_EN;
          par_d   = frame_parity(FIFO_DO, BIT8, ODD_N_EVEN);
          state_d = ST_START;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_START: begin
        if (bit_done) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt == last_bit) state_d = pe_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (bit_done) state_d = ST_STOP;
      end
      ST_STOP: begin
        // Back-to-back frames go straight to the next pop without an idle bit.
        if (bit_done) state_d = FIFO_EMPTY ? ST_IDLE : ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
    rdb_d  = (state_d != ST_FETCH);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      rdb_q   <= 1'b1;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      bit8_q  <= 1'b1;
      pe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      rdb_q   <= rdb_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      bit8_q  <= bit8_d;
      pe_q    <= pe_d;
    end
  end

  always_ff @(posedge CLK) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  assign FIFO_RDB = rdb_q;
  assign TX       = tx_q;
  assign TX_BUSY  = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three instances (read latency 1, 2, 3), each fed
// by its own FIFO model; frames are checked bit by bit against a frame model.
module tb_uart_tx_serializer;

  logic       CLK        = 1'b0;
  logic       RESET_N    = 1'b1;
  logic       BAUD_TICK  = 1'b0;
  logic       BIT8       = 1'b1;
  logic       PARITY_EN  = 1'b0;
  logic       ODD_N_EVEN = 1'b0;
  logic [2:0] empty, rdb, tx, busy;
  logic [7:0] fdo [3];

  logic [7:0] mem [3][16];
  int         wr_ptr [3];
  int         rd_ptr [3];
  logic [2:0] pv [3];
  logic [7:0] pd [3][3];
  int         pulses [3];
  int         viol [3];

  int tick_period = 4;
  int tick_cnt    = 0;
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0]  b;
    logic        b8;
    logic        pe;
    logic        odd;
    logic [10:0] eb;
    int          len;
  } vec_t;
  vec_t tbl [7];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 3; g++) begin : gi
    uart_tx_serializer #(.RD_LATENCY(g + 1)) u_dut (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .BAUD_TICK  (BAUD_TICK),
      .BIT8       (BIT8),
      .PARITY_EN  (PARITY_EN),
      .ODD_N_EVEN (ODD_N_EVEN),
      .FIFO_EMPTY (empty[g]),
      .FIFO_DO    (fdo[g]),
      .FIFO_RDB   (rdb[g]),
      .TX         (tx[g]),
      .TX_BUSY    (busy[g])
    );
  end

  // FIFO model: data appears RD_LATENCY cycles after the strobe cycle, zero otherwise.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      empty[k] = (rd_ptr[k] == wr_ptr[k]);
      fdo[k]   = pv[k][k] ? pd[k][k] : 8'h00;
    end
  end

  always @(posedge CLK) begin
    for (int k = 0; k < 3; k++) begin
      pv[k]    <= {pv[k][1:0], (!rdb[k] && !empty[k])};
      pd[k][2] <= pd[k][1];
      pd[k][1] <= pd[k][0];
      pd[k][0] <= mem[k][rd_ptr[k] % 16];
      if (!rdb[k] && !empty[k]) rd_ptr[k] <= rd_ptr[k] + 1;
    end
  end

  always @(negedge CLK) begin
    for (int k = 0; k < 3; k++) begin
      if (!rdb[k]) begin
        pulses[k] = pulses[k] + 1;
        if (empty[k]) viol[k] = viol[k] + 1;
      end
    end
  end

  always @(posedge CLK) begin
    #1;
    if (tick_cnt >= tick_period - 1) begin
      BAUD_TICK = 1'b1;
      tick_cnt  = 0;
    end else begin
      BAUD_TICK = 1'b0;
      tick_cnt  = tick_cnt + 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] b);
    mem[i][wr_ptr[i] % 16] = b;
    wr_ptr[i] = wr_ptr[i] + 1;
  endtask

  // Frame as a list of line levels, index 0 first on the wire.
  function automatic void frame_model(input logic [7:0] b, input logic b8, input logic pe,
                                      input logic odd, output logic [10:0] bits, output int len);
    int n;
    int ones;
    n    = b8 ? 8 : 7;
    ones = 0;
    bits = '0;
    len  = 0;
    bits[len] = 1'b0;
    len++;
    for (int k = 0; k < n; k++) begin
      bits[len] = b[k];
      ones += int'(b[k]);
      len++;
    end
    if (pe) begin
      bits[len] = ((ones % 2) == 1) ^ odd;
      len++;
    end
    bits[len] = 1'b1;
    len++;
  endfunction

  task automatic run_frame(input int i, input logic [7:0] b, input logic b8, input logic pe,
                           input logic odd, input logic [10:0] eb, input int elen,
                           input bit pop_now, input bit last, input string tag);
    int       cnt;
    int       ticks;
    int       bi;
    int       cyc;
    bit       busy_bad;
    logic [1:0] seen;
    BIT8 = b8;
    PARITY_EN = pe;
    ODD_N_EVEN = odd;
    if (pop_now) begin
      chk({tag, "_b2b_pop"}, int'(rdb[i]), 0);
    end else begin
      cnt = 0;
      while (rdb[i] !== 1'b0 && cnt < 200) begin
        @(negedge CLK);
        cnt++;
      end
      if (rdb[i] !== 1'b0) begin
        chk({tag, "_pop_timeout"}, int'(rdb[i]), 0);
        return;
      end
    end
    chk({tag, "_busy_at_pop"}, int'(busy[i]), 1);
    @(negedge CLK);
    cnt = 1;
    chk({tag, "_rdb_width"}, int'(rdb[i]), 1);
    while (tx[i] !== 1'b0 && cnt < 8) begin
      @(negedge CLK);
      cnt++;
    end
    chk({tag, "_tx_fall_cycle"}, cnt, i + 2);
    if (tx[i] !== 1'b0) return;
    BIT8       = 1'($urandom);
    PARITY_EN  = 1'($urandom);
    ODD_N_EVEN = 1'($urandom);
    ticks = 0;
    bi = 0;
    cyc = 0;
    seen = 2'b00;
    busy_bad = 1'b0;
    cnt = 0;
    while (ticks < 16 * elen && cnt < 16 * elen * tick_period + 64) begin
      seen |= (tx[i] === 1'b1) ? 2'b10 : 2'b01;
      if (busy[i] !== 1'b1 || rdb[i] !== 1'b1) busy_bad = 1'b1;
      cyc++;
      if (BAUD_TICK) begin
        ticks++;
        if (ticks % 16 == 0) begin
          chk($sformatf("%s_bit%0d_levels", tag, bi), int'(seen), eb[bi] ? 2 : 1);
          if (bi > 0) chk($sformatf("%s_bit%0d_width", tag, bi), cyc, 16 * tick_period);
          bi++;
          cyc = 0;
          seen = 2'b00;
        end
      end
      @(negedge CLK);
      cnt++;
    end
    chk({tag, "_frame_ticks"}, ticks, 16 * elen);
    chk({tag, "_busy_rdb_in_frame"}, int'(busy_bad), 0);
    if (last) begin
      chk({tag, "_busy_after"}, int'(busy[i]), 0);
      chk({tag, "_tx_after"}, int'(tx[i]), 1);
    end
  endtask

  initial begin
    logic [10:0] eb;
    int          el;
    int          cnt;
    int          ticks;
    int          p0;
    int          rb, tb, bb;
    int          inst, nb;
    logic [7:0]  rb_b [3];
    logic        rb_c [3][3];

    tbl[0] = '{8'h55, 1'b1, 1'b0, 1'b0, 11'h2AA, 10};
    tbl[1] = '{8'hA3, 1'b0, 1'b1, 1'b0, 11'h346, 10};
    tbl[2] = '{8'hA3, 1'b0, 1'b1, 1'b1, 11'h246, 10};
    tbl[3] = '{8'hFF, 1'b1, 1'b1, 1'b0, 11'h5FE, 11};
    tbl[4] = '{8'h00, 1'b0, 1'b0, 1'b0, 11'h100, 9};
    tbl[5] = '{8'h80, 1'b0, 1'b1, 1'b1, 11'h300, 10};
    tbl[6] = '{8'h01, 1'b1, 1'b1, 1'b1, 11'h402, 11};

    #2 RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_tx", int'(tx), 7);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rdb", int'(rdb), 7);
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);

    tick_period = 4;
    for (int t = 0; t < 7; t++) begin
      push(1, tbl[t].b);
      run_frame(1, tbl[t].b, tbl[t].b8, tbl[t].pe, tbl[t].odd, tbl[t].eb, tbl[t].len,
                1'b0, 1'b1, $sformatf("tbl%0d", t));
      repeat (3) @(negedge CLK);
    end

    tick_period = 2;
    rb = 0; tb = 0; bb = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge CLK);
      if (rdb !== 3'b111) rb++;
      if (tx !== 3'b111) tb++;
      if (busy !== 3'b000) bb++;
    end
    chk("idle_rdb_low_cycles", rb, 0);
    chk("idle_tx_low_cycles", tb, 0);
    chk("idle_busy_cycles", bb, 0);

    tick_period = 1;
    p0 = pulses[1];
    push(1, 8'h12);
    push(1, 8'h34);
    push(1, 8'h56);
    rb_b[0] = 8'h12; rb_b[1] = 8'h34; rb_b[2] = 8'h56;
    for (int k = 0; k < 3; k++) begin
      frame_model(rb_b[k], 1'b1, 1'b0, 1'b0, eb, el);
      run_frame(1, rb_b[k], 1'b1, 1'b0, 1'b0, eb, el, k > 0, k == 2, $sformatf("burst%0d", k));
    end
    repeat (5) @(negedge CLK);
    chk("burst_rdb_pulses", pulses[1] - p0, 3);

    for (int i = 0; i < 3; i++) begin
      frame_model(8'hFF, 1'b1, 1'b0, 1'b0, eb, el);
      push(i, 8'hFF);
      run_frame(i, 8'hFF, 1'b1, 1'b0, 1'b0, eb, el, 1'b0, 1'b1, $sformatf("lat%0d", i + 1));
      repeat (3) @(negedge CLK);
    end

    tick_period = 2;
    BIT8 = 1'b1; PARITY_EN = 1'b0; ODD_N_EVEN = 1'b0;
    push(1, 8'hC5);
    cnt = 0;
    while (rdb[1] !== 1'b0 && cnt < 200) begin
      @(negedge CLK);
      cnt++;
    end
    chk("rst_pop", int'(rdb[1]), 0);
    cnt = 0;
    while (tx[1] !== 1'b0 && cnt < 10) begin
      @(negedge CLK);
      cnt++;
    end
    chk("rst_fall", int'(tx[1]), 0);
    ticks = 0;
    cnt = 0;
    while (ticks < 16 * 4 + 8 && cnt < 1000) begin
      if (BAUD_TICK) ticks++;
      @(negedge CLK);
      cnt++;
    end
    chk("rst_reach_bit3", ticks, 72);
    chk("rst_pre_tx", int'(tx[1]), 0);
    chk("rst_pre_busy", int'(busy[1]), 1);
    #2 RESET_N = 1'b0;
    #1;
    chk("rst_async_tx", int'(tx[1]), 1);
    chk("rst_async_busy", int'(busy[1]), 0);
    chk("rst_async_rdb", int'(rdb[1]), 1);
    @(negedge CLK);
    push(1, 8'h5A);
    @(negedge CLK);
    RESET_N = 1'b1;
    frame_model(8'h5A, 1'b1, 1'b0, 1'b0, eb, el);
    run_frame(1, 8'h5A, 1'b1, 1'b0, 1'b0, eb, el, 1'b0, 1'b1, "post_rst");
    repeat (3) @(negedge CLK);

    for (int r = 0; r < 15; r++) begin
      inst = $urandom_range(0, 2);
      nb = $urandom_range(1, 3);
      tick_period = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) begin
        rb_b[k] = 8'($urandom);
        rb_c[k][0] = 1'($urandom);
        rb_c[k][1] = 1'($urandom);
        rb_c[k][2] = 1'($urandom);
        push(inst, rb_b[k]);
      end
      for (int k = 0; k < nb; k++) begin
        frame_model(rb_b[k], rb_c[k][0], rb_c[k][1], rb_c[k][2], eb, el);
        run_frame(inst, rb_b[k], rb_c[k][0], rb_c[k][1], rb_c[k][2], eb, el, k > 0,
                  k == nb - 1, $sformatf("rnd%0d_%0d", r, k));
      end
      repeat (4) @(negedge CLK);
    end

    chk("rdb_low_while_empty", viol[0] + viol[1] + viol[2], 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
